// File: rtl/prewish_blinky.sv
// prewish_blinky
//   Mask player downstream of the mentor stage. A rising edge on STB_I
//   loads the 8-bit mask on DAT_I. The mask is then played out on LED_O,
//   MSB first, with each bit held for 2^PRESCALER_BITS clocks. Playback
//   loops until a new mask is loaded. Loading zero stops playback and
//   parks the LED low.
//
// Ports
//   CLK_I    system clock, rising edge
//   RST_I    asynchronous reset, active low
//   STB_I    load strobe; a sampled rising edge requests a load
//   DAT_I    [7:0] mask, sampled only on the accepting edge
//   ACK_O    one-cycle pulse following each accepted load
//   LED_O    current mask bit (0 while idle)
//   FRAME_O  one-cycle pulse when playback wraps from bit 0 back to bit 7
//   BUSY_O   high while a non-zero mask is playing
//
// All outputs are registered.
module prewish_blinky #(
  parameter int PRESCALER_BITS = 3
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       STB_I,
  input  logic [7:0] DAT_I,
  output logic       ACK_O,
  output logic       LED_O,
  output logic       FRAME_O,
  output logic       BUSY_O
);

  // A 2-bit encoding leaves unused codes. The default branch of the case
  // statement pulls them back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01
  } state_t;

  state_t                    state;
  logic [7:0]                mask_reg;
  logic [2:0]                bit_idx;
  logic [PRESCALER_BITS-1:0] prescale;
  logic                      stb_prev;

  logic       load;
  logic       tick;
  logic [2:0] nxt_idx;

  // A strobe held high produces only one load. A strobe that is already
  // high at reset release loads on the first edge, because stb_prev
  // resets to 0.
  assign load    = STB_I & ~stb_prev;
  // The prescaler is at its terminal count, so this is the last cycle of
  // the current bit.
  assign tick    = &prescale;
  // Wraps 0 -> 7 naturally (modulo 8).
  assign nxt_idx = bit_idx - 3'd1;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state    <= IDLE;
      mask_reg <= 8'h00;
      bit_idx  <= 3'd7;
      prescale <= '0;
      stb_prev <= 1'b0;
      ACK_O    <= 1'b0;
      LED_O    <= 1'b0;
      FRAME_O  <= 1'b0;
      BUSY_O   <= 1'b0;
    end else begin
      stb_prev <= STB_I;
      ACK_O    <= load;
      FRAME_O  <= 1'b0;

      if (load) begin
        // A load restarts playback from bit 7. Any tick on this same edge
        // is dropped.
        mask_reg <= DAT_I;
        prescale <= '0;
        bit_idx  <= 3'd7;
        if (DAT_I != 8'h00) begin
          state  <= RUN;
          LED_O  <= DAT_I[7];
          BUSY_O <= 1'b1;
        end else begin
          state  <= IDLE;
          LED_O  <= 1'b0;
          BUSY_O <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            prescale <= '0;
            LED_O    <= 1'b0;
            BUSY_O   <= 1'b0;
          end
          RUN: begin
            prescale <= prescale + 1'b1;
            BUSY_O   <= 1'b1;
            if (tick) begin
              bit_idx <= nxt_idx;
              LED_O   <= mask_reg[nxt_idx];
              if (bit_idx == 3'd0) FRAME_O <= 1'b1;
            end
          end
          default: begin
            state    <= IDLE;
            prescale <= '0;
            bit_idx  <= 3'd7;
            LED_O    <= 1'b0;
            BUSY_O   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
